// File: rtl/div_unit_e_pkg.sv
// Shared definitions for the E-stage divider: FSM states, widths and HI/LO
// field positions. Imported by div_step and div_unit_e.
package div_unit_e_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  localparam int LO_LSB = 0;
  localparam int LO_MSB = DIV_WIDTH - 1;
  localparam int HI_LSB = DIV_WIDTH;
  localparam int HI_MSB = 2 * DIV_WIDTH - 1;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/div_unit_e_div_step.sv
// One radix-2 restoring divide iteration, purely combinational.
// Ports: rem/quo/divisor in -> rem_nxt/quo_nxt out.
module div_step
  import div_unit_e_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  logic           borrow;

  // One extra bit so the shifted partial remainder never overflows.
  assign sh     = {rem, quo[WIDTH-1]};
  assign diff   = sh - {1'b0, divisor};
  assign borrow = diff[WIDTH];

  always_comb begin
    rem_nxt = diff[WIDTH-1:0];
    if (borrow) rem_nxt = sh[WIDTH-1:0];
  end

  assign quo_nxt = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_unit_e.sv
// E-stage iterative DIV/DIVU unit: stall, {HI,LO} result and done flag.
// Ports: clk, rst(n), flushE, stall_extE, div_*E in; div_stallE/resultE/doneE.
// Option: DIV_EARLY_OUT_EN skips iteration when |a| < |b| and b != 0.
module div_unit_e
  import div_unit_e_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flushE,
  input  logic               stall_extE,
  input  logic               div_validE,
  input  logic               div_signedE,
  input  logic [WIDTH-1:0]   srcaE,
  input  logic [WIDTH-1:0]   srcbE,
  output logic               div_stallE,
  output logic [2*WIDTH-1:0] div_resultE,
  output logic               div_doneE
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] a_raw;
  logic             neg_q;
  logic             neg_r;
  logic             by_zero;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign a_abs = (div_signedE & srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign b_abs = (div_signedE & srcbE[WIDTH-1]) ? -srcbE : srcbE;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvsr),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign q_fix = neg_q ? -quo_nxt : quo_nxt;
  assign r_fix = neg_r ? -rem_nxt : rem_nxt;

  // Gated by rst so the pipeline never sees a stall while in reset.
  assign div_stallE = rst & div_validE & ~flushE
                    & (state != DIV_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= DIV_IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      a_raw       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      by_zero     <= 1'b0;
      div_resultE <= '0;
      div_doneE   <= 1'b0;
    end else if (flushE) begin
      state     <= DIV_IDLE;
      div_doneE <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (div_validE) begin
            rem     <= '0;
            quo     <= a_abs;
            dvsr    <= b_abs;
            a_raw   <= srcaE;
            neg_q   <= div_signedE
                     & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            neg_r   <= div_signedE & srcaE[WIDTH-1];
            by_zero <= (srcbE == '0);
            cnt     <= '0;
`ifdef DIV_EARLY_OUT_EN
            if ((srcbE != '0) && (a_abs < b_abs)) begin
              state       <= DIV_DONE;
              div_resultE <= {srcaE, {WIDTH{1'b0}}};
              div_doneE   <= 1'b1;
            end else begin
              state <= DIV_BUSY;
            end
`else
            state <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DIV_DONE;
            div_doneE <= 1'b1;
            // b == 0: raw dividend in HI, all-ones in LO, no sign fix.
            if (by_zero)
              div_resultE <= {a_raw, {WIDTH{1'b1}}};
            else
              div_resultE <= {r_fix, q_fix};
          end
        end
        DIV_DONE: begin
          if (!stall_extE) begin
            state     <= DIV_IDLE;
            div_doneE <= 1'b0;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_e.sv
// Directed self-checking bench for div_unit_e.
// Honours DIV_EARLY_OUT_EN for the expected stall length of short divides.
module tb_div_unit_e;

  logic        clk;
  logic        rst_n;
  logic        flushE;
  logic        stall_extE;
  logic        div_validE;
  logic        div_signedE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        div_stallE;
  logic [63:0] div_resultE;
  logic        div_doneE;

  int checks;
  int failures;

`ifdef DIV_EARLY_OUT_EN
  localparam int SHORT_CYC = 1;
`else
  localparam int SHORT_CYC = 33;
`endif

  div_unit_e dut (
    .clk         (clk),
    .rst         (rst_n),
    .flushE      (flushE),
    .stall_extE  (stall_extE),
    .div_validE  (div_validE),
    .div_signedE (div_signedE),
    .srcaE       (srcaE),
    .srcbE       (srcbE),
    .div_stallE  (div_stallE),
    .div_resultE (div_resultE),
    .div_doneE   (div_doneE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_div(input string tag,
                         input logic sgn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [63:0] exp,
                         input int exp_cyc,
                         input int hold);
    int n;
    @(posedge clk);
    #1;
    div_validE  = 1'b1;
    div_signedE = sgn;
    srcaE       = a;
    srcbE       = b;
    stall_extE  = (hold > 0);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!div_stallE) break;
      n++;
    end
    check({tag, "_cyc"}, 64'(n), 64'(exp_cyc));
    check({tag, "_res"}, div_resultE, exp);
    check({tag, "_done"}, 64'(div_doneE), 64'd1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hstall"}, 64'(div_stallE), 64'd0);
        check({tag, "_hdone"}, 64'(div_doneE), 64'd1);
        check({tag, "_hres"}, div_resultE, exp);
      end
      @(posedge clk);
      #1;
      stall_extE = 1'b0;
      @(negedge clk);
      check({tag, "_rdone"}, 64'(div_doneE), 64'd1);
      check({tag, "_rstall"}, 64'(div_stallE), 64'd0);
    end
    @(posedge clk);
    #1;
    div_validE = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 64'(div_doneE), 64'd0);
    check({tag, "_keep"}, div_resultE, exp);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    flushE      = 1'b0;
    stall_extE  = 1'b0;
    div_validE  = 1'b0;
    div_signedE = 1'b0;
    srcaE       = '0;
    srcbE       = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(div_stallE), 64'd0);
    check("rst_done", 64'(div_doneE), 64'd0);
    check("rst_res", div_resultE, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7,
            {32'd2, 32'd14}, 33, 0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            {32'h0, 32'h8000_0000}, 33, 0);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0,
            {32'd5, 32'hFFFF_FFFF}, 33, 0);
    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0,
            {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 33, 0);

    // Flush at BUSY cycle 10; previous result must survive.
    @(posedge clk);
    #1;
    div_validE  = 1'b1;
    div_signedE = 1'b0;
    srcaE       = 32'd1000;
    srcbE       = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    flushE = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(div_stallE), 64'd0);
    @(posedge clk);
    #1;
    flushE     = 1'b0;
    div_validE = 1'b0;
    @(negedge clk);
    check("flush_done", 64'(div_doneE), 64'd0);
    check("flush_res", div_resultE,
          {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    check("flush_idle", 64'(div_stallE), 64'd0);

    run_div("divu_9_3", 1'b0, 32'd9, 32'd3,
            {32'd0, 32'd3}, 33, 0);
    run_div("ext_stall", 1'b0, 32'd50, 32'd5,
            {32'd0, 32'd10}, 33, 5);
    run_div("divu_3_10", 1'b0, 32'd3, 32'd10,
            {32'd3, 32'd0}, SHORT_CYC, 0);
    run_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10,
            {32'hFFFF_FFFD, 32'd0}, SHORT_CYC, 0);
    run_div("divu_0_7", 1'b0, 32'd0, 32'd7,
            {32'd0, 32'd0}, SHORT_CYC, 0);
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9,
            {32'd2, 32'hFFFF_FFF2}, 33, 0);

    // Async reset mid-BUSY after a nonzero result.
    run_div("divu_77_5", 1'b0, 32'd77, 32'd5,
            {32'd2, 32'd15}, 33, 0);
    @(posedge clk);
    #1;
    div_validE  = 1'b1;
    div_signedE = 1'b0;
    srcaE       = 32'd100;
    srcbE       = 32'd7;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_stall", 64'(div_stallE), 64'd0);
    check("arst_done", 64'(div_doneE), 64'd0);
    check("arst_res", div_resultE, 64'd0);
    div_validE = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_div("post_rst", 1'b0, 32'd100, 32'd7,
            {32'd2, 32'd14}, 33, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit_e.md
Name: div_unit_e

Overview:
- Iterative radix-2 restoring divider in the E stage; executes MIPS DIV/DIVU.
- Produces the E-stage divide stall consumed by the pipeline hazard logic, which freezes F–W while it is high.
- Delivers the 64-bit {remainder, quotient} result to the HI/LO write path.
- Honours pipeline flushes and external stalls so results are neither lost nor duplicated.

Parameters:
- WIDTH, 32, operand width in bits; the result is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- flushE  in  1  E-stage flush (exception, mispredict); cancels the operation in progress
- stall_extE  in  1  non-divider stalls holding E frozen (cache stalls, mult stall)
- div_validE  in  1  the instruction in E is DIV/DIVU
- div_signedE  in  1  1 = DIV (signed), 0 = DIVU
- srcaE  in  WIDTH  dividend (rs)
- srcbE  in  WIDTH  divisor (rt)
- div_stallE  out  1  E must hold; divider not finished
- div_resultE  out  2*WIDTH  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO)
- div_doneE  out  1  div_resultE is valid for the instruction currently in E

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, div_resultE=0, div_doneE=0. div_stallE is 0 during reset.
- FSM states: IDLE, BUSY, DONE.
- div_stallE = div_validE & ~flushE & (state != DONE). It is combinational, so the stall asserts in the same cycle the DIV reaches E.
- IDLE:
  - If div_validE & ~flushE: latch |srcaE| and |srcbE| (raw operands if unsigned), div_signedE, sign(a) and sign(b); clear the counter; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - One restoring step per cycle: shift {rem, quo} left by 1, trial-subtract the divisor, set the quotient bit.
  - After WIDTH steps (counter == WIDTH-1), go to DONE.
  - Register the sign-corrected result on the same edge and set div_doneE=1.
- DONE:
  - div_stallE=0 and the result is held.
  - If stall_extE=1, stay in DONE (E has not advanced).
  - If stall_extE=0, go to IDLE and clear div_doneE; div_resultE keeps its value.
- Latency: cycle 0 = IDLE capture, then WIDTH BUSY cycles. div_stallE is high for WIDTH+1 cycles (33); the result is valid in cycle WIDTH+1.
- Sign rules when signed:
  - Quotient is negated iff sign(a) xor sign(b).
  - Remainder takes the sign of a.
  - Arithmetic is modulo 2^WIDTH.
  - -2^31 / -1 gives quotient 0x80000000, remainder 0.
- Divide by zero (full-length path, WIDTH+1 stall cycles):
  - Quotient = 0xFFFFFFFF and remainder = srcaE, regardless of sign mode.
  - Sign correction is not applied.
- flushE=1 in any state: next state IDLE, div_doneE=0, and div_resultE is not updated. A flush in the same cycle as a new div_validE does not start an operation.
- Back-to-back DIVs: DONE→IDLE on release; the next DIV in E is captured on the following cycle.
- div_validE dropping mid-BUSY without a flush is illegal and not checked.

Optional Feature:
- DIV_EARLY_OUT_EN, defined:
  - In IDLE, if divisor ≠ 0 and |a| < |b| (includes a=0), go straight to DONE on the next edge.
  - The result is quotient=0, remainder=srcaE; div_stallE is high for exactly 1 cycle.
- Not defined: every division takes the full WIDTH+1 cycles. Results are identical in both builds.

Decomposition:
- Shared package (e.g. cpu_defs_pkg) holds:
  - the FSM state enum (IDLE, BUSY, DONE);
  - DIV_WIDTH=32;
  - DIV_CNT_W=$clog2(DIV_WIDTH);
  - the HI/LO field-slice constants.
- Sub-module div_step: purely combinational, one restoring iteration. Inputs rem, quo, divisor; outputs next rem, next quo. It keeps the FSM file small and is unit-testable.

Test Plan:
- DIVU 100/7 with stall_extE=0:
  - div_stallE is high for exactly 33 cycles, then low.
  - div_resultE = {0x2, 0xE}; the state returns to IDLE next cycle.
- DIV -7/2:
  - Quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
  - DIV 0x80000000/0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- DIVU 5/0 and DIV -5/0:
  - Both give quotient 0xFFFFFFFF and remainder = srcaE (0x5 and 0xFFFFFFFB respectively).
  - 33 stall cycles each.
- flushE pulsed at BUSY cycle 10:
  - The divider is IDLE next cycle, div_doneE=0, and div_resultE is unchanged from the previous value.
  - A following DIVU 9/3 completes normally with {0, 3}.
- Completion while stall_extE=1 for 5 cycles:
  - The divider stays in DONE with div_stallE=0, div_doneE=1 and the result stable.
  - It leaves DONE on the first cycle stall_extE=0. No second operation starts while the same instruction is still in E.
- With DIV_EARLY_OUT_EN defined, DIVU 3/10: div_stallE high 1 cycle, result {3, 0}. rst driven low mid-BUSY: all outputs 0 immediately (async).
